// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage MIPS datapath plus the MEM/WB pipeline register.
// Byte-lane data RAM with synchronous read, load extraction and a debug read port.
module mem_access_stage #(
    parameter int PROC_BITS      = 32,
    parameter int PC_BITS        = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int MEM_ADDR_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [PROC_BITS-1:0]      i_alu_result,
    input  logic [PROC_BITS-1:0]      i_store_data,
    input  logic [PC_BITS-1:0]        i_pc_return,
    input  logic [REG_ADDRS_BITS-1:0] i_rd,
    input  logic                      i_MemRead,
    input  logic                      i_MemWrite,
    input  logic [1:0]                i_mem_size,
    input  logic                      i_mem_unsigned,
    input  logic                      i_RegWrite,
    input  logic                      i_MemtoReg,
    input  logic                      i_pc_to_reg,
    input  logic                      i_halt,
    input  logic [MEM_ADDR_BITS-1:0]  i_dbg_addr,
    output logic [PROC_BITS-1:0]      o_alu_data,
    output logic [PROC_BITS-1:0]      o_mem_data,
    output logic [PC_BITS-1:0]        o_pc_return,
    output logic [REG_ADDRS_BITS-1:0] o_rd,
    output logic                      o_RegWrite,
    output logic                      o_MemtoReg,
    output logic                      o_pc_to_reg,
    output logic                      o_halt,
    output logic                      o_misaligned,
    output logic [PROC_BITS-1:0]      o_dbg_data
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int LANES = PROC_BITS / 8;

    logic [PROC_BITS-1:0] ram [DEPTH];

    logic [MEM_ADDR_BITS-1:0] word_idx;
    logic [1:0]               offset;
    logic                     aligned;
    logic [LANES-1:0]         byte_we;
    logic [PROC_BITS-1:0]     wr_word;

    logic [PROC_BITS-1:0]      alu_data_q, alu_data_d;
    logic [PC_BITS-1:0]        pc_return_q, pc_return_d;
    logic [REG_ADDRS_BITS-1:0] rd_q, rd_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      pc_to_reg_q, pc_to_reg_d;
    logic                      halt_q, halt_d;
    logic                      misaligned_q, misaligned_d;
    logic                      load_q, load_d;
    logic [1:0]                off_q, off_d;
    logic [1:0]                size_q, size_d;
    logic                      unsigned_q, unsigned_d;
    logic [PROC_BITS-1:0]      rd_word_q;
    logic [PROC_BITS-1:0]      dbg_data_q;

    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [PROC_BITS-1:0] mem_data;

    assign word_idx = i_alu_result[MEM_ADDR_BITS+1:2];
    assign offset   = i_alu_result[1:0];

    always_comb begin
        case (i_mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~offset[0];
            default: aligned = (offset == 2'b00);
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        byte_we = '0;
        wr_word = i_store_data;
        if (i_MemWrite && i_enable && aligned && !rst) begin
            case (i_mem_size)
                2'b00: begin
                    byte_we = {{(LANES-1){1'b0}}, 1'b1} << offset;
                    wr_word = {LANES{i_store_data[7:0]}};
                end
                2'b01: begin
                    byte_we = offset[1] ? 4'b1100 : 4'b0011;
                    wr_word = {(LANES/2){i_store_data[15:0]}};
                end
                default: byte_we = '1;
            endcase
        end
    end

    always_comb begin
        alu_data_d   = alu_data_q;
        pc_return_d  = pc_return_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        pc_to_reg_d  = pc_to_reg_q;
        halt_d       = halt_q;
        load_d       = load_q;
        off_d        = off_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        misaligned_d = misaligned_q;
        if (i_enable) begin
            alu_data_d   = i_alu_result;
            pc_return_d  = i_pc_return;
            rd_d         = i_rd;
            reg_write_d  = i_RegWrite;
            mem_to_reg_d = i_MemtoReg;
            pc_to_reg_d  = i_pc_to_reg;
            halt_d       = i_halt;
            load_d       = i_MemRead & aligned;
            off_d        = offset;
            size_d       = i_mem_size;
            unsigned_d   = i_mem_unsigned;
            misaligned_d = misaligned_q | ((i_MemRead | i_MemWrite) & ~aligned);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_data_q   <= '0;
            pc_return_q  <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_to_reg_q  <= 1'b0;
            halt_q       <= 1'b0;
            load_q       <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            alu_data_q   <= alu_data_d;
            pc_return_q  <= pc_return_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            pc_to_reg_q  <= pc_to_reg_d;
            halt_q       <= halt_d;
            load_q       <= load_d;
            off_q        <= off_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (byte_we[b]) ram[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
        if (i_enable) rd_word_q <= ram[word_idx];
        if (rst) dbg_data_q <= '0;
        else     dbg_data_q <= ram[i_dbg_addr];
    end

    always_comb begin
        sel_byte = rd_word_q[{off_q, 3'b000} +: 8];
        sel_half = rd_word_q[{off_q[1], 4'b0000} +: 16];
        mem_data = '0;
        if (load_q) begin
            case (size_q)
                2'b00:   mem_data = {{(PROC_BITS-8){~unsigned_q & sel_byte[7]}}, sel_byte};
                2'b01:   mem_data = {{(PROC_BITS-16){~unsigned_q & sel_half[15]}}, sel_half};
                default: mem_data = rd_word_q;
            endcase
        end
    end

    assign o_alu_data   = alu_data_q;
    assign o_mem_data   = mem_data;
    assign o_pc_return  = pc_return_q;
    assign o_rd         = rd_q;
    assign o_RegWrite   = reg_write_q;
    assign o_MemtoReg   = mem_to_reg_q;
    assign o_pc_to_reg  = pc_to_reg_q;
    assign o_halt       = halt_q;
    assign o_misaligned = misaligned_q;
    assign o_dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads/stores, lanes, misalignment,
// freeze, debug port and pass-through, with hand-computed expected values.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        i_enable;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic [31:0] i_pc_return;
    logic [4:0]  i_rd;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic        i_RegWrite;
    logic        i_MemtoReg;
    logic        i_pc_to_reg;
    logic        i_halt;
    logic [9:0]  i_dbg_addr;
    logic [31:0] o_alu_data;
    logic [31:0] o_mem_data;
    logic [31:0] o_pc_return;
    logic [4:0]  o_rd;
    logic        o_RegWrite;
    logic        o_MemtoReg;
    logic        o_pc_to_reg;
    logic        o_halt;
    logic        o_misaligned;
    logic [31:0] o_dbg_data;

    int checks = 0;
    int errors = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data),
        .i_pc_return(i_pc_return), .i_rd(i_rd),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
        .i_RegWrite(i_RegWrite), .i_MemtoReg(i_MemtoReg),
        .i_pc_to_reg(i_pc_to_reg), .i_halt(i_halt), .i_dbg_addr(i_dbg_addr),
        .o_alu_data(o_alu_data), .o_mem_data(o_mem_data),
        .o_pc_return(o_pc_return), .o_rd(o_rd),
        .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg),
        .o_pc_to_reg(o_pc_to_reg), .o_halt(o_halt),
        .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one memory request, advance one edge, then settle before sampling.
    task automatic drive_mem(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] data);
        i_MemRead      = rd;
        i_MemWrite     = wr;
        i_mem_size     = sz;
        i_mem_unsigned = uns;
        i_alu_result   = addr;
        i_store_data   = data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_enable = 1'b1; i_rd = 5'd17; i_pc_return = 32'h1234_5678;
        i_RegWrite = 1'b1; i_MemtoReg = 1'b1; i_pc_to_reg = 1'b1; i_halt = 1'b1;
        i_dbg_addr = 10'd3;
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
        checks++;
        if ({o_alu_data, o_mem_data, o_pc_return, o_dbg_data} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h %h %h %h exp all 0", o_alu_data, o_mem_data, o_pc_return, o_dbg_data);
        end
        checks++;
        if ({o_rd, o_RegWrite, o_MemtoReg, o_pc_to_reg, o_halt, o_misaligned} !== 10'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got rd=%0d flags=%b%b%b%b%b exp 0", o_rd, o_RegWrite, o_MemtoReg, o_pc_to_reg, o_halt, o_misaligned);
        end
        rst = 1'b0; i_RegWrite = 1'b0; i_MemtoReg = 1'b0; i_pc_to_reg = 1'b0; i_halt = 1'b0;
        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hCAFE_F00D);
        rst = 1'b1;
        drive_mem(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h1234_5678);
        rst = 1'b0;
        checks++;
        if (o_mem_data !== 32'h0 || o_alu_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_second got mem=%h alu=%h exp 0 0", o_mem_data, o_alu_data);
        end
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        checks++;
        if (o_mem_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL ram_kept got %h exp cafef00d", o_mem_data);
        end
    endtask

    task automatic test_loads;
        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h8000_80FF);
        drive_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        checks++;
        if (o_mem_data !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL lb_10 got %h exp ffffffff", o_mem_data);
        end
        drive_mem(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checks++;
        if (o_mem_data !== 32'h0000_0080) begin
            errors++; $display("[TB] FAIL lbu_11 got %h exp 00000080", o_mem_data);
        end
        drive_mem(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checks++;
        if (o_mem_data !== 32'hFFFF_8000) begin
            errors++; $display("[TB] FAIL lh_12 got %h exp ffff8000", o_mem_data);
        end
        drive_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        checks++;
        if (o_mem_data !== 32'h0000_80FF) begin
            errors++; $display("[TB] FAIL lhu_10 got %h exp 000080ff", o_mem_data);
        end
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checks++;
        if (o_mem_data !== 32'h8000_80FF || o_alu_data !== 32'h10) begin
            errors++; $display("[TB] FAIL lw_10 got mem=%h alu=%h exp 800080ff 00000010", o_mem_data, o_alu_data);
        end
        drive_mem(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checks++;
        if (o_mem_data !== 32'h0) begin
            errors++; $display("[TB] FAIL no_load got %h exp 0", o_mem_data);
        end
    endtask

    task automatic test_partial_stores;
        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1122_3344);
        drive_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA);
        drive_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        checks++;
        if (o_mem_data !== 32'hBEEF_AA44) begin
            errors++; $display("[TB] FAIL lanes_20 got %h exp beefaa44", o_mem_data);
        end
    endtask

    task automatic test_read_before_write;
        i_dbg_addr = 10'd8;
        drive_mem(1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0BAD_F00D);
        checks++;
        if (o_mem_data !== 32'hBEEF_AA44) begin
            errors++; $display("[TB] FAIL rbw_load got %h exp beefaa44", o_mem_data);
        end
        checks++;
        if (o_dbg_data !== 32'hBEEF_AA44) begin
            errors++; $display("[TB] FAIL dbg_old got %h exp beefaa44", o_dbg_data);
        end
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        checks++;
        if (o_mem_data !== 32'h0BAD_F00D || o_dbg_data !== 32'h0BAD_F00D) begin
            errors++; $display("[TB] FAIL rbw_new got mem=%h dbg=%h exp 0badf00d", o_mem_data, o_dbg_data);
        end
    endtask

    task automatic test_misaligned;
        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h0102_0304);
        checks++;
        if (o_misaligned !== 1'b0) begin
            errors++; $display("[TB] FAIL misal_clear got %b exp 0", o_misaligned);
        end
        drive_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000_FFFF);
        checks++;
        if (o_misaligned !== 1'b1) begin
            errors++; $display("[TB] FAIL misal_sh got %b exp 1", o_misaligned);
        end
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h32, 32'h0);
        checks++;
        if (o_mem_data !== 32'h0 || o_misaligned !== 1'b1) begin
            errors++; $display("[TB] FAIL misal_lw got mem=%h flag=%b exp 0 1", o_mem_data, o_misaligned);
        end
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
        checks++;
        if (o_mem_data !== 32'h0102_0304 || o_misaligned !== 1'b1) begin
            errors++; $display("[TB] FAIL misal_sticky got mem=%h flag=%b exp 01020304 1", o_mem_data, o_misaligned);
        end
        rst = 1'b1;
        drive_mem(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        checks++;
        if (o_misaligned !== 1'b0) begin
            errors++; $display("[TB] FAIL misal_rst got %b exp 0", o_misaligned);
        end
    endtask

    task automatic test_freeze;
        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h1357_9BDF);
        i_rd = 5'd5; i_RegWrite = 1'b1; i_MemtoReg = 1'b1;
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        i_enable = 1'b0; i_dbg_addr = 10'd4;
        for (int c = 0; c < 3; c++) begin
            i_rd = 5'(c + 9); i_RegWrite = 1'b0; i_MemtoReg = 1'b0; i_halt = 1'b1;
            if (c == 2) drive_mem(1'b1, 1'b1, 2'b01, 1'b1, 32'h41, 32'h0000_1111);
            else        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h40 + 32'(c), 32'hDEAD_BEEF);
            checks++;
            if (o_mem_data !== 32'h1357_9BDF || o_alu_data !== 32'h40 || o_rd !== 5'd5 ||
                o_RegWrite !== 1'b1 || o_MemtoReg !== 1'b1 || o_halt !== 1'b0 || o_misaligned !== 1'b0) begin
                errors++;
                $display("[TB] FAIL freeze_%0d got mem=%h alu=%h rd=%0d rw=%b m2r=%b halt=%b mis=%b exp 13579bdf 40 5 1 1 0 0",
                         c, o_mem_data, o_alu_data, o_rd, o_RegWrite, o_MemtoReg, o_halt, o_misaligned);
            end
            checks++;
            if (o_dbg_data !== 32'h8000_80FF) begin
                errors++; $display("[TB] FAIL freeze_dbg_%0d got %h exp 800080ff", c, o_dbg_data);
            end
        end
        i_enable = 1'b1; i_halt = 1'b0;
        drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        checks++;
        if (o_mem_data !== 32'h1357_9BDF) begin
            errors++; $display("[TB] FAIL unfreeze_lw got %h exp 13579bdf", o_mem_data);
        end
    endtask

    task automatic test_passthrough;
        i_rd = 5'd31; i_pc_to_reg = 1'b1; i_pc_return = 32'h0000_0024;
        i_RegWrite = 1'b1; i_halt = 1'b1; i_MemtoReg = 1'b0;
        drive_mem(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_1010, 32'h0);
        checks++;
        if (o_rd !== 5'd31 || o_pc_to_reg !== 1'b1 || o_pc_return !== 32'h24 ||
            o_RegWrite !== 1'b1 || o_halt !== 1'b1 || o_MemtoReg !== 1'b0 || o_alu_data !== 32'h1010) begin
            errors++;
            $display("[TB] FAIL passthru got rd=%0d p2r=%b pc=%h rw=%b halt=%b m2r=%b alu=%h exp 31 1 24 1 1 0 1010",
                     o_rd, o_pc_to_reg, o_pc_return, o_RegWrite, o_halt, o_MemtoReg, o_alu_data);
        end
        i_pc_to_reg = 1'b0; i_halt = 1'b0; i_RegWrite = 1'b0;
        drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_1010, 32'hA5A5_5A5A);
        drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        checks++;
        if (o_mem_data !== 32'hA5A5_5A5A) begin
            errors++; $display("[TB] FAIL wrap_1010 got %h exp a5a55a5a", o_mem_data);
        end
    endtask

    initial begin
        rst = 1'b1; i_enable = 1'b1; i_alu_result = '0; i_store_data = '0; i_pc_return = '0;
        i_rd = '0; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_mem_size = 2'b11; i_mem_unsigned = 1'b0;
        i_RegWrite = 1'b0; i_MemtoReg = 1'b0; i_pc_to_reg = 1'b0; i_halt = 1'b0; i_dbg_addr = '0;
        @(negedge clk);
        test_reset();
        test_loads();
        test_partial_stores();
        test_read_before_write();
        test_misaligned();
        test_freeze();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
